// File: rtl/zynq_pl_pkg.sv
// Shared PL definitions: response status and default MMIO read timeout.
package zynq_pl_pkg;

  typedef enum logic {
    RESP_OK      = 1'b0,
    RESP_TIMEOUT = 1'b1
  } resp_status_e;

  localparam int default_timeout_lp = 1024;

endpackage

// File: rtl/axil_mmio_order_tracker.sv
// Tracks request order, read wait time and timed-out reads whose data is still owed.
module axil_mmio_order_tracker
  import zynq_pl_pkg::*;
#(
  parameter int els_p     = 4,
  parameter int timeout_p = default_timeout_lp,
  localparam int cnt_w_lp = $clog2(els_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                push_v_i,
  input  logic                push_is_read_i,
  input  logic                pop_i,
  input  logic                rdata_avail_i,
  input  logic                dev_rdata_v_i,
  output logic                ready_o,
  output logic                head_v_o,
  output logic                head_is_read_o,
  output resp_status_e        status_o,
  output logic                capture_o,
  output logic [cnt_w_lp-1:0] outstanding_o,
  output logic [cnt_w_lp-1:0] drop_cnt_o,
  output logic [15:0]         err_count_o
);

  localparam int wait_w_lp = (timeout_p > 0) ? $clog2(timeout_p + 1) : 1;
  localparam logic [wait_w_lp-1:0] wait_max_lp = wait_w_lp'(timeout_p);

  logic                 waiting;
  logic                 expired;
  logic                 timeout_pop;
  logic                 drop_zero;
  logic                 drop_inc;
  logic                 drop_dec;
  logic                 late_reg, late_next;
  logic [wait_w_lp-1:0] wait_reg, wait_next;
  logic [cnt_w_lp-1:0]  drop_reg, drop_next;
  logic [15:0]          err_reg, err_next;

  bsg_fifo_1r1w_small #(
    .width_p(1),
    .els_p  (els_p)
  ) order_fifo (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .v_i          (push_v_i),
    .ready_param_o(ready_o),
    .data_i       (push_is_read_i),
    .v_o          (head_v_o),
    .data_o       (head_is_read_o),
    .yumi_i       (pop_i),
    .count_o      (outstanding_o)
  );

  assign drop_zero   = (drop_reg == '0);
  assign waiting     = head_v_o & head_is_read_o & ~rdata_avail_i;
  assign expired     = (timeout_p > 0) && waiting && (wait_reg == wait_max_lp);
  assign status_o    = expired ? RESP_TIMEOUT : RESP_OK;
  assign timeout_pop = pop_i & expired;
  // Data landing while the head shows a timeout belongs to that head and is dropped.
  assign capture_o   = dev_rdata_v_i & drop_zero & ~expired;
  assign drop_cnt_o  = drop_reg;
  assign err_count_o = err_reg;

  always_comb begin
    wait_next = wait_reg;
    if (pop_i)
      wait_next = '0;
    else if (waiting && !dev_rdata_v_i && !expired && (timeout_p > 0))
      wait_next = wait_reg + wait_w_lp'(1);

    late_next = late_reg;
    if (pop_i)
      late_next = 1'b0;
    else if (expired && dev_rdata_v_i && drop_zero)
      late_next = 1'b1;

    // A timed-out read whose data already came back is not owed any more.
    drop_inc  = timeout_pop && !late_reg && !(dev_rdata_v_i && drop_zero);
    drop_dec  = dev_rdata_v_i && !drop_zero;
    drop_next = drop_reg + cnt_w_lp'(drop_inc) - cnt_w_lp'(drop_dec);

    err_next = err_reg;
    if (timeout_pop && (err_reg != 16'hFFFF))
      err_next = err_reg + 16'd1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wait_reg <= '0;
      late_reg <= 1'b0;
      drop_reg <= '0;
      err_reg  <= '0;
    end else begin
      wait_reg <= wait_next;
      late_reg <= late_next;
      drop_reg <= drop_next;
      err_reg  <= err_next;
    end
  end

endmodule

// File: rtl/bsg_fifo_1r1w_small.sv
// Small register-based FIFO with a combinational head; els_p must be a power of 2.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 8,
  parameter int els_p   = 4,
  localparam int ptr_w_lp = $clog2(els_p),
  localparam int cnt_w_lp = $clog2(els_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                v_i,
  output logic                ready_param_o,
  input  logic [width_p-1:0]  data_i,
  output logic                v_o,
  output logic [width_p-1:0]  data_o,
  input  logic                yumi_i,
  output logic [cnt_w_lp-1:0] count_o
);

  logic [width_p-1:0]  mem_reg [els_p];
  logic [ptr_w_lp-1:0] wptr_reg;
  logic [ptr_w_lp-1:0] rptr_reg;
  logic [cnt_w_lp-1:0] count_reg;
  logic                push;
  logic                pop;

  assign ready_param_o = (count_reg != cnt_w_lp'(els_p));
  assign v_o           = (count_reg != '0);
  assign push          = v_i & ready_param_o;
  assign pop           = yumi_i & v_o;
  assign data_o        = mem_reg[rptr_reg];
  assign count_o       = count_reg;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) wptr_reg <= wptr_reg + ptr_w_lp'(1);
      if (pop)  rptr_reg <= rptr_reg + ptr_w_lp'(1);
      count_reg <= count_reg + cnt_w_lp'(push) - cnt_w_lp'(pop);
    end
  end

  // Storage needs no reset; only entries behind a valid count are ever read.
  always_ff @(posedge clk_i) begin
    if (push) mem_reg[wptr_reg] <= data_i;
  end

endmodule

// File: rtl/axil_mmio_bridge.sv
// Command-to-MMIO bridge returning in-order responses with read timeout recovery.
module axil_mmio_bridge
  import zynq_pl_pkg::*;
#(
  parameter int data_width_p = 32,
  parameter int addr_width_p = 32,
  parameter int size_width_p = 2,
  parameter int els_p        = 4,
  parameter int timeout_p    = default_timeout_lp,
  localparam int cnt_w_lp    = $clog2(els_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    cmd_v_i,
  output logic                    cmd_ready_and_o,
  input  logic [addr_width_p-1:0] cmd_addr_i,
  input  logic                    cmd_wr_en_i,
  input  logic [size_width_p-1:0] cmd_data_size_i,
  input  logic [data_width_p-1:0] cmd_wdata_i,
  output logic [addr_width_p-1:0] dev_addr_o,
  output logic                    dev_write_en_o,
  output logic                    dev_read_en_o,
  output logic [size_width_p-1:0] dev_op_size_o,
  output logic [data_width_p-1:0] dev_wdata_o,
  input  logic [data_width_p-1:0] dev_rdata_i,
  input  logic                    dev_rdata_v_i,
  output logic                    resp_v_o,
  input  logic                    resp_ready_and_i,
  output logic [data_width_p-1:0] resp_rdata_o,
  output logic                    resp_err_o,
  output logic [cnt_w_lp-1:0]     outstanding_o,
  output logic [15:0]             err_count_o
);

  localparam logic [cnt_w_lp:0] els_lim_lp = (cnt_w_lp + 1)'(els_p);

  logic                    ready_en_reg;
  logic                    order_ready;
  logic                    accept;
  logic                    head_v;
  logic                    head_is_read;
  logic                    capture;
  logic                    data_ready;
  logic                    data_v;
  logic                    data_pop;
  logic                    resp_fire;
  logic                    timed_out;
  logic [data_width_p-1:0] data_head;
  logic [cnt_w_lp-1:0]     drop_cnt;
  logic [cnt_w_lp-1:0]     data_count;
  logic [cnt_w_lp:0]       in_use;
  resp_status_e            status;

  // Holds off commands until the first clock edge after reset release.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) ready_en_reg <= 1'b0;
    else            ready_en_reg <= 1'b1;
  end

  assign in_use          = {1'b0, outstanding_o} + {1'b0, drop_cnt};
  assign cmd_ready_and_o = ready_en_reg & order_ready & (in_use < els_lim_lp);
  assign accept          = cmd_v_i & cmd_ready_and_o;

  assign dev_addr_o      = cmd_addr_i;
  assign dev_op_size_o   = cmd_data_size_i;
  assign dev_wdata_o     = cmd_wdata_i;
  assign dev_write_en_o  = accept & cmd_wr_en_i;
  assign dev_read_en_o   = accept & ~cmd_wr_en_i;

  assign timed_out    = (status == RESP_TIMEOUT);
  assign resp_v_o     = head_v & (~head_is_read | data_v | timed_out);
  assign resp_err_o   = resp_v_o & timed_out;
  assign resp_rdata_o = (head_v & head_is_read & data_v) ? data_head : '0;
  assign resp_fire    = resp_v_o & resp_ready_and_i;
  assign data_pop     = resp_fire & head_is_read & data_v;

  axil_mmio_order_tracker #(
    .els_p    (els_p),
    .timeout_p(timeout_p)
  ) tracker (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .push_v_i      (accept),
    .push_is_read_i(~cmd_wr_en_i),
    .pop_i         (resp_fire),
    .rdata_avail_i (data_v),
    .dev_rdata_v_i (dev_rdata_v_i),
    .ready_o       (order_ready),
    .head_v_o      (head_v),
    .head_is_read_o(head_is_read),
    .status_o      (status),
    .capture_o     (capture),
    .outstanding_o (outstanding_o),
    .drop_cnt_o    (drop_cnt),
    .err_count_o   (err_count_o)
  );

  bsg_fifo_1r1w_small #(
    .width_p(data_width_p),
    .els_p  (els_p)
  ) rdata_fifo (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .v_i          (capture & data_ready),
    .ready_param_o(data_ready),
    .data_i       (dev_rdata_i),
    .v_o          (data_v),
    .data_o       (data_head),
    .yumi_i       (data_pop),
    .count_o      (data_count)
  );

  // Read data never outnumbers queued requests; the count is only a sanity bound.
  logic unused_ok;
  assign unused_ok = ^data_count;

endmodule
